// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC measurement sequencer.
package tdc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StSettle,
        StCapture,
        StConvert,
        StDone
    } state_e;

    localparam int unsigned DefN         = 512;
    localparam int unsigned DefW         = 64;
    localparam int unsigned DefChunks    = DefN / DefW;
    localparam int unsigned DefChunkIdxW = (DefChunks > 1) ? $clog2(DefChunks) : 1;

    // Count width able to hold the value n itself (all-ones code).
    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned idx_w_of(input int unsigned chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/therm_chunk.sv
// One slice of thermometer-to-binary conversion: popcount plus bubble detect,
// chained to the previous slice through its MSB.
module therm_chunk #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]       chunk_i,
    input  logic               carry_i,
    output logic [$clog2(W):0] count_o,
    output logic               bubble_o,
    output logic               msb_o
);

    localparam int unsigned CntW = $clog2(W) + 1;

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CntW'(chunk_i[i]);
        end
        // A one sitting above a zero breaks the thermometer pattern.
        bubble_o = |(chunk_i & ~{chunk_i[W-2:0], carry_i});
        msb_o    = chunk_i[W-1];
    end

endmodule

// File: rtl/tdc_seq.sv
// Measurement sequencer for the scntr shift counter: pulse, settle, capture,
// chunked thermometer conversion, valid/ready result and a flush hold-off.
module tdc_seq
    import tdc_pkg::*;
#(
    parameter int unsigned N          = DefN,
    parameter int unsigned W          = DefW,
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned FLUSH_CYC  = 512,
    parameter int unsigned CW         = cw_of(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_in,
    input  logic [N-1:0]  i_code,
    output logic [CW-1:0] o_count,
    output logic          o_err,
    output logic          o_valid,
    input  logic          i_ready
);

    localparam int unsigned NChunks   = N / W;
    localparam int unsigned IdxW      = idx_w_of(NChunks);
    localparam int unsigned ChunkCntW = $clog2(W) + 1;

    state_e                        state_q, state_d;
    logic [7:0]                    phase_q;
    logic [15:0]                   flush_q;
    logic [IdxW-1:0]               idx_q;
    logic [NChunks-1:0][W-1:0]     code_q;
    logic [CW-1:0]                 acc_q;
    logic                          bub_q;
    logic                          prev_q;
    logic                          in_q;
    logic                          valid_q;
    logic [CW-1:0]                 count_q;
    logic                          err_q;

    logic                          phase_done;
    logic                          last_chunk;
    logic                          flush_zero;
    logic [ChunkCntW-1:0]          chunk_cnt;
    logic                          chunk_bub;
    logic                          chunk_msb;
    logic [CW-1:0]                 acc_sum;
    logic                          bub_any;

    therm_chunk #(
        .W (W)
    ) u_chunk (
        .chunk_i  (code_q[idx_q]),
        .carry_i  (prev_q),
        .count_o  (chunk_cnt),
        .bubble_o (chunk_bub),
        .msb_o    (chunk_msb)
    );

    always_comb begin
        phase_done = (state_q == StPulse) ? (phase_q == 8'(PULSE_CYC - 1))
                                          : (phase_q == 8'(SETTLE_CYC - 1));
        last_chunk = (idx_q == IdxW'(NChunks - 1));
        flush_zero = (flush_q == '0);
        acc_sum    = acc_q + CW'(chunk_cnt);
        bub_any    = bub_q | chunk_bub;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (i_start && flush_zero) state_d = StPulse;
            StPulse:   if (phase_done) state_d = StSettle;
            StSettle:  if (phase_done) state_d = StCapture;
            StCapture: state_d = StConvert;
            StConvert: if (last_chunk) state_d = StDone;
            StDone:    if (i_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= '0;
            flush_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            acc_q   <= '0;
            bub_q   <= 1'b0;
            prev_q  <= 1'b1;
            in_q    <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            in_q    <= (state_d == StPulse);
            valid_q <= (state_d == StDone);
            phase_q <= (state_d == state_q && (state_q == StPulse || state_q == StSettle))
                       ? phase_q + 8'd1 : 8'd0;

            if (state_q == StCapture) begin
                flush_q <= 16'(FLUSH_CYC);
            end else if (!flush_zero) begin
                flush_q <= flush_q - 16'd1;
            end

            if (state_q == StCapture) begin
                code_q <= i_code;
                acc_q  <= '0;
                bub_q  <= 1'b0;
                prev_q <= 1'b1;  // bit 0 has no lower neighbour to violate
                idx_q  <= '0;
            end else if (state_q == StConvert) begin
                acc_q  <= acc_sum;
                bub_q  <= bub_any;
                prev_q <= chunk_msb;
                idx_q  <= idx_q + IdxW'(1);
                if (last_chunk) begin
                    count_q <= acc_sum;
                    err_q   <= bub_any;
                end
            end
        end
    end

    always_comb begin
        o_busy  = (state_q != StIdle) || !flush_zero;
        o_in    = in_q;
        o_valid = valid_q;
        o_count = count_q;
        o_err   = err_q;
    end

endmodule

// File: doc/tdc_seq.md
Name: tdc_seq

Overview:
- Measurement sequencer for the 512-stage shift counter (scntr) in the ADPLL time-to-digital path.
- On request it drives a pulse of fixed width into the counter's `i_in`, then waits for the chain to settle.
- It then captures the counter's thermometer output and converts it to a binary edge count over several cycles. It also flags bubbles in the code.
- The result goes to the loop filter through a valid/ready handshake, and the block enforces a flush interval before the next measurement.

Parameters:
- N, 512, counter chain length; equals width of `i_code`.
- W, 64, bits converted per cycle; power of 2; N mod W == 0.
- PULSE_CYC, 4, cycles `o_in` is held high per measurement; 1..255.
- SETTLE_CYC, 8, cycles between pulse end and capture; 1..255.
- FLUSH_CYC, 512, minimum cycles from capture to next pulse start, so the chain clears; 1..65535.
- CW, $clog2(N)+1, width of `o_count`.

Ports:
- i_clk, in, 1, system clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_start, in, 1, measurement request; sampled only when accepted (see Behaviour).
- o_busy, out, 1, high whenever a request would not be accepted.
- o_in, out, 1, drives scntr `i_in`; registered.
- i_code, in, N, scntr `o_out` thermometer code.
- o_count, out, CW, number of ones in the captured code.
- o_err, out, 1, captured code was not a clean thermometer code.
- o_valid, out, 1, result valid.
- i_ready, in, 1, consumer accepts result.

Behaviour:
- Reset (asynchronous, effective immediately): state IDLE; o_in=0, o_valid=0, o_err=0, o_count=0, o_busy=0; all counters 0.
- States: IDLE, PULSE, SETTLE, CAPTURE, CONVERT, DONE.
- IDLE:
  - o_busy = (flush counter != 0).
  - If i_start=1 and the flush counter is 0 at an edge, go to PULSE. o_in rises at that same edge.
  - i_start is ignored otherwise. It is never queued.
- PULSE: o_in=1 for exactly PULSE_CYC cycles, then SETTLE. o_in falls at the same edge.
- SETTLE: o_in=0 for SETTLE_CYC cycles, then CAPTURE.
- CAPTURE (1 cycle):
  - Register i_code into a local N-bit buffer.
  - Load the flush counter with FLUSH_CYC.
  - Clear the accumulator and the bubble flag.
- CONVERT (N/W cycles): per cycle, process chunk k (bits kW..kW+W-1, LSB chunk first).
  - Add popcount(chunk) to the accumulator.
  - Set the bubble flag if any bit i has code[i]=1 and code[i-1]=0, for i>0.
  - The previous bit across the chunk boundary comes from the last bit of chunk k-1.
  - After the last chunk, load o_count and o_err, set o_valid, go to DONE.
- DONE:
  - Hold o_valid, o_count and o_err stable until i_valid&i_ready… precisely, until o_valid & i_ready at an edge.
  - On that edge, clear o_valid and go to IDLE.
  - o_count and o_err keep their last values after the handshake.
- o_busy=1 in all states other than IDLE.
- The flush counter decrements every cycle while nonzero, in every state, and saturates at 0.
- Latency: o_valid rises PULSE_CYC+SETTLE_CYC+1+N/W edges after the edge that accepted i_start. With defaults that is 4+8+1+8 = 21.
- Widths:
  - The accumulator is CW bits, so it cannot overflow; an all-ones code gives o_count=N=512.
  - An all-zero code gives o_count=0, o_err=0.
- Reset mid-operation: o_in drops at once, and any partial result is discarded, never presented.
- i_code is only sampled in CAPTURE. Changes at any other time have no effect.

Decomposition:
- Package tdc_pkg holds:
  - the state encoding enum;
  - the localparams for N/W chunk count and the chunk-index width;
  - a function giving CW from N.
- One sub-module, therm_chunk: combinational, W-bit popcount plus bubble detect, with a carry-in bit for the previous chunk's MSB. It outputs the chunk count, the bubble flag and the chunk MSB.
- The FSM, counters and buffer stay in tdc_seq.

Test Plan:
- Reset, then i_start=1 for 1 cycle with i_code=all-zero:
  - o_in is high for exactly 4 cycles, starting at the accepting edge.
  - o_valid rises 21 edges after acceptance.
  - o_count=0, o_err=0.
- i_code = 37 LSB ones, held through capture: o_count=37, o_err=0. Repeat with 511 ones and with 512 ones: o_count=511 and 512 respectively.
- Bubble code: ones at bits 0..99 and a single one at bit 130 → o_count=101, o_err=1.
- Bubble at a chunk boundary: ones at 0..62 and at 64 → o_err=1.
- Backpressure and flush:
  - Hold i_ready=0 for 10 cycles after o_valid: result stays stable and o_valid stays high.
  - Raise i_ready: o_valid clears on the next edge.
  - A new i_start is rejected (o_busy=1, no o_in pulse) until 512 cycles after CAPTURE, and accepted on the first cycle after that.
- Assert i_rst during PULSE and again during CONVERT:
  - o_in=0 and o_valid=0 immediately, before the next clock edge.
  - State is IDLE.
  - No o_valid from the aborted measurement.
  - A new i_start is accepted right after release.
